// File: rtl/cordic_pkg.sv
// Shared constants and types for the sequential CORDIC engine.
// Angles are degrees in signed 8.24 fixed point; the datapath carries
// two guard bits above the 32-bit operands.
package cordic_pkg;

  localparam int XW        = 32;  // operand width
  localparam int DW        = 34;  // datapath width (2 guard bits)
  localparam int ZW        = 32;  // angle width
  localparam int FRAC      = 24;  // fractional bits of the angle format
  localparam int AW        = 6;   // arctangent ROM address width
  localparam int NITER_DEF = 24;  // default number of micro-rotations

  // CORDIC gain K ~= 1.64676 in 8.24, for scaling expectations
  localparam logic [31:0] K_GAIN_Q24 = 32'd27628053;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  // Sign-extend a 32-bit operand into the 34-bit datapath
  function automatic logic signed [DW-1:0] sext(input logic signed [XW-1:0] v);
    return {{(DW - XW){v[XW-1]}}, v};
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation.
// i_d_pos selects d=+1 (1) or d=-1 (0):
//   x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan.
// All sums wrap at their width; no saturation.
module cordic_stage
  import cordic_pkg::*;
(
  input  logic signed [DW-1:0] i_x,
  input  logic signed [DW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic        [AW-1:0] i_shift,
  input  logic signed [ZW-1:0] i_atan,
  input  logic                 i_d_pos,
  output logic signed [DW-1:0] o_x,
  output logic signed [DW-1:0] o_y,
  output logic signed [ZW-1:0] o_z
);

  logic signed [DW-1:0] w_x_sh;
  logic signed [DW-1:0] w_y_sh;

  assign w_x_sh = i_x >>> i_shift;
  assign w_y_sh = i_y >>> i_shift;

  assign o_x = i_d_pos ? (i_x - w_y_sh) : (i_x + w_y_sh);
  assign o_y = i_d_pos ? (i_y + w_x_sh) : (i_y - w_x_sh);
  assign o_z = i_d_pos ? (i_z - i_atan) : (i_z + i_atan);

endmodule

// File: rtl/cordic_seq.sv
// Sequential CORDIC: one micro-rotation per clock, arctangent ROM external
// (o_atan_addr -> i_atan_data, combinational in the same cycle).
// start/busy/done handshake; results hold until the next completion.
// Optional feature: define CORDIC_VECTORING_EN to add i_mode
// (0 = rotation, 1 = vectoring); without it the block rotates only.
module cordic_seq
  import cordic_pkg::*;
#(
  parameter int NITER = NITER_DEF  // legal 8..32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
`ifdef CORDIC_VECTORING_EN
  input  logic                 i_mode,
`endif
  input  logic signed [XW-1:0] i_xin,
  input  logic signed [XW-1:0] i_yin,
  input  logic signed [ZW-1:0] i_zin,
  output logic        [AW-1:0] o_atan_addr,
  input  logic signed [ZW-1:0] i_atan_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic signed [DW-1:0] o_xout,
  output logic signed [DW-1:0] o_yout,
  output logic signed [ZW-1:0] o_zout
);

  localparam logic [AW-1:0] LAST_I = AW'(NITER - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_accept;
  logic                 w_last;
  logic        [AW-1:0] r_i;
  logic signed [DW-1:0] r_x;
  logic signed [DW-1:0] r_y;
  logic signed [ZW-1:0] r_z;
  logic                 r_done;
  logic signed [DW-1:0] r_xout;
  logic signed [DW-1:0] r_yout;
  logic signed [ZW-1:0] r_zout;
  logic                 w_d_pos;
  logic signed [DW-1:0] w_x_nxt;
  logic signed [DW-1:0] w_y_nxt;
  logic signed [ZW-1:0] w_z_nxt;

`ifdef CORDIC_VECTORING_EN
  logic r_mode;
  // Vectoring drives y toward zero; rotation drives z toward zero
  assign w_d_pos = r_mode ? r_y[DW-1] : ~r_z[ZW-1];
`else
  assign w_d_pos = ~r_z[ZW-1];
`endif

  cordic_stage u_stage (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_i),
    .i_atan  (i_atan_data),
    .i_d_pos (w_d_pos),
    .o_x     (w_x_nxt),
    .o_y     (w_y_nxt),
    .o_z     (w_z_nxt)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking (<=) so every flop samples pre-edge values; blocking here creates order-dependent races.
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: accept start only in IDLE, leave ITER on the last step
  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missed branch would infer a latch.
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ITER;
        end
      end
      ITER: begin
        if (r_i == LAST_I) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, rotate each ITER cycle, publish on the last step
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: datapath and result registers are reset too, so an aborted run leaves outputs at 0.
    if (i_rst) begin
      r_i    <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_done <= 1'b0;
      r_xout <= '0;
      r_yout <= '0;
      r_zout <= '0;
`ifdef CORDIC_VECTORING_EN
      r_mode <= 1'b0;
`endif
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_x <= sext(i_xin);
        r_y <= sext(i_yin);
        r_z <= i_zin;
        r_i <= '0;
`ifdef CORDIC_VECTORING_EN
        r_mode <= i_mode;
`endif
      end else if (r_state == ITER) begin
        r_x <= w_x_nxt;
        r_y <= w_y_nxt;
        r_z <= w_z_nxt;
        r_i <= w_last ? '0 : r_i + AW'(1);
        if (w_last) begin
          r_xout <= w_x_nxt;
          r_yout <= w_y_nxt;
          r_zout <= w_z_nxt;
        end
      end
    end
  end

  assign o_atan_addr = (r_state == ITER) ? r_i : '0;
  assign o_busy      = (r_state == ITER);
  assign o_done      = r_done;
  assign o_xout      = r_xout;
  assign o_yout      = r_yout;
  assign o_zout      = r_zout;

endmodule
